// File: rtl/ysyx_25040111_lsu.sv
// Memory-access / writeback stage: one instruction in flight, single-outstanding data bus.
// Optional misalignment trap enabled by defining YSYX_25040111_MISALIGN_CHK_EN.
module ysyx_25040111_lsu #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              abt_valid,
    output logic              abt_ready,
    input  logic              abt_men,
    input  logic              abt_write,
    input  logic [31:0]       abt_addr,
    input  logic [31:0]       abt_wdata,
    input  logic [1:0]        abt_mask,
    input  logic              abt_rsign,
    input  logic [4:0]        abt_ard,
    input  logic [31:0]       abt_rd,
    input  logic              abt_gen,
    input  logic [11:0]       abt_acsr,
    input  logic [31:0]       abt_csr,
    input  logic              abt_sen,
    input  logic [31:0]       abt_pc,
    input  logic              erri,
    input  logic [3:0]        errtpi,
    output logic              abt_finish,
    output logic [4:0]        abt_frd,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic              mem_wen,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [3:0]        mem_wstrb,
    input  logic              mem_resp_valid,
    output logic              mem_resp_ready,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_resp_err,
    output logic              gpr_wen,
    output logic [4:0]        gpr_waddr,
    output logic [31:0]       gpr_wdata,
    output logic              csr_wen,
    output logic [11:0]       csr_waddr,
    output logic [31:0]       csr_wdata,
    output logic [31:0]       commit_pc,
    output logic              erro,
    output logic [3:0]        errtpo
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP, S_WB} state_t;

    state_t      state_q, state_d;
    logic        men_q, write_q, rsign_q, gen_q, sen_q, erri_q, resp_err_q;
    logic [31:0] addr_q, wdata_q, rd_q, csr_q, pc_q, rdata_q;
    logic [1:0]  mask_q;
    logic [4:0]  ard_q;
    logic [11:0] acsr_q;
    logic [3:0]  errtpi_q;

    logic        mis_in, mis_q, err_any, is_load;
    logic [31:0] shifted, load_ext;
    logic [3:0]  err_code;

`ifdef YSYX_25040111_MISALIGN_CHK_EN
    assign mis_in = abt_men & (((abt_mask == 2'b10) & abt_addr[0]) |
                               ((abt_mask == 2'b11) & (abt_addr[1:0] != 2'b00)));
    assign mis_q  = men_q & (((mask_q == 2'b10) & addr_q[0]) |
                             ((mask_q == 2'b11) & (addr_q[1:0] != 2'b00)));
`else
    assign mis_in = 1'b0;
    assign mis_q  = 1'b0;
`endif

    assign is_load = men_q & ~write_q;
    assign err_any = erri_q | resp_err_q | mis_q;

    always_comb begin
        err_code = 4'd0;
        if (erri_q)          err_code = errtpi_q;
        else if (mis_q)      err_code = write_q ? 4'd6 : 4'd4;
        else if (resp_err_q) err_code = write_q ? 4'd7 : 4'd5;
    end

    // Bus request fields come straight from the latched instruction, so they stay stable in REQ.
    assign mem_wen  = write_q;
    assign mem_addr = ADDR_W'({addr_q[31:2], 2'b00});

    always_comb begin
        mem_wstrb = 4'h0;
        mem_wdata = wdata_q;
        case (mask_q)
            2'b01: begin
                mem_wstrb = 4'b0001 << addr_q[1:0];
                mem_wdata = {4{wdata_q[7:0]}};
            end
            2'b10: begin
                mem_wstrb = 4'b0011 << addr_q[1:0];
                mem_wdata = {2{wdata_q[15:0]}};
            end
            2'b11:   mem_wstrb = 4'hF;
            default: mem_wstrb = 4'h0;
        endcase
    end

    assign shifted = rdata_q >> {addr_q[1:0], 3'b000};

    always_comb begin
        case (mask_q)
            2'b01:   load_ext = rsign_q ? {{24{shifted[7]}}, shifted[7:0]}
                                        : {24'd0, shifted[7:0]};
            2'b10:   load_ext = rsign_q ? {{16{shifted[15]}}, shifted[15:0]}
                                        : {16'd0, shifted[15:0]};
            default: load_ext = shifted;
        endcase
    end

    assign gpr_waddr = ard_q;
    assign gpr_wdata = is_load ? load_ext : rd_q;
    assign csr_waddr = acsr_q;
    assign csr_wdata = csr_q;

    always_comb begin
        state_d        = state_q;
        abt_ready      = 1'b0;
        mem_req_valid  = 1'b0;
        mem_resp_ready = 1'b0;
        abt_finish     = 1'b0;
        abt_frd        = '0;
        commit_pc      = '0;
        gpr_wen        = 1'b0;
        csr_wen        = 1'b0;
        erro           = 1'b0;
        errtpo         = '0;
        case (state_q)
            S_IDLE: begin
                abt_ready = 1'b1;
                if (abt_valid) state_d = (abt_men & ~mis_in) ? S_REQ : S_WB;
            end
            S_REQ: begin
                mem_req_valid = 1'b1;
                if (mem_req_ready) state_d = S_RESP;
            end
            S_RESP: begin
                mem_resp_ready = 1'b1;
                if (mem_resp_valid) state_d = S_WB;
            end
            S_WB: begin
                abt_finish = 1'b1;
                abt_frd    = ard_q;
                commit_pc  = pc_q;
                gpr_wen    = gen_q & (ard_q != 5'd0) & ~err_any & ~(men_q & write_q);
                csr_wen    = sen_q;
                erro       = err_any;
                errtpo     = err_code;
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= S_IDLE;
            men_q      <= 1'b0;
            write_q    <= 1'b0;
            rsign_q    <= 1'b0;
            gen_q      <= 1'b0;
            sen_q      <= 1'b0;
            erri_q     <= 1'b0;
            resp_err_q <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rd_q       <= '0;
            csr_q      <= '0;
            pc_q       <= '0;
            rdata_q    <= '0;
            mask_q     <= '0;
            ard_q      <= '0;
            acsr_q     <= '0;
            errtpi_q   <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_IDLE && abt_valid) begin
                men_q      <= abt_men;
                write_q    <= abt_write;
                rsign_q    <= abt_rsign;
                gen_q      <= abt_gen;
                sen_q      <= abt_sen;
                erri_q     <= erri;
                addr_q     <= abt_addr;
                wdata_q    <= abt_wdata;
                rd_q       <= abt_rd;
                csr_q      <= abt_csr;
                pc_q       <= abt_pc;
                mask_q     <= abt_mask;
                ard_q      <= abt_ard;
                acsr_q     <= abt_acsr;
                errtpi_q   <= errtpi;
                rdata_q    <= '0;
                resp_err_q <= 1'b0;
            end
            if (state_q == S_RESP && mem_resp_valid) begin
                rdata_q    <= mem_rdata;
                resp_err_q <= mem_resp_err;
            end
        end
    end

endmodule

// File: tb/tb_ysyx_25040111_lsu.sv
// Directed self-checking bench for ysyx_25040111_lsu; inputs change and outputs are sampled on negedge.
module tb_ysyx_25040111_lsu;

    logic        clock = 1'b0, reset = 1'b1;
    logic        abt_valid = 1'b0, abt_ready, abt_men = 1'b0, abt_write = 1'b0;
    logic [31:0] abt_addr = '0, abt_wdata = '0, abt_rd = '0, abt_csr = '0, abt_pc = '0;
    logic [1:0]  abt_mask = '0;
    logic        abt_rsign = 1'b0, abt_gen = 1'b0, abt_sen = 1'b0, erri = 1'b0;
    logic [4:0]  abt_ard = '0, abt_frd, gpr_waddr;
    logic [11:0] abt_acsr = '0, csr_waddr;
    logic [3:0]  errtpi = '0, mem_wstrb, errtpo;
    logic        abt_finish, mem_req_valid, mem_req_ready = 1'b0, mem_wen;
    logic [31:0] mem_addr, mem_wdata, mem_rdata = '0, gpr_wdata, csr_wdata, commit_pc;
    logic        mem_resp_valid = 1'b0, mem_resp_ready, mem_resp_err = 1'b0;
    logic        gpr_wen, csr_wen, erro;

    int n_tests = 0, n_fail = 0;

    ysyx_25040111_lsu #(.ADDR_W(32), .DATA_W(32)) dut (
        .clock(clock), .reset(reset),
        .abt_valid(abt_valid), .abt_ready(abt_ready), .abt_men(abt_men), .abt_write(abt_write),
        .abt_addr(abt_addr), .abt_wdata(abt_wdata), .abt_mask(abt_mask), .abt_rsign(abt_rsign),
        .abt_ard(abt_ard), .abt_rd(abt_rd), .abt_gen(abt_gen), .abt_acsr(abt_acsr),
        .abt_csr(abt_csr), .abt_sen(abt_sen), .abt_pc(abt_pc), .erri(erri), .errtpi(errtpi),
        .abt_finish(abt_finish), .abt_frd(abt_frd),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_wen(mem_wen),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_resp_valid(mem_resp_valid), .mem_resp_ready(mem_resp_ready),
        .mem_rdata(mem_rdata), .mem_resp_err(mem_resp_err),
        .gpr_wen(gpr_wen), .gpr_waddr(gpr_waddr), .gpr_wdata(gpr_wdata),
        .csr_wen(csr_wen), .csr_waddr(csr_waddr), .csr_wdata(csr_wdata),
        .commit_pc(commit_pc), .erro(erro), .errtpo(errtpo)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic offer(input logic men, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [1:0] mask, input logic rsign,
                         input logic [4:0] ard, input logic [31:0] rd);
        abt_valid = 1'b1; abt_men = men; abt_write = wr; abt_addr = addr; abt_wdata = wdata;
        abt_mask = mask; abt_rsign = rsign; abt_ard = ard; abt_rd = rd; abt_gen = 1'b1;
        abt_pc = 32'h8000_1000; abt_sen = 1'b0; erri = 1'b0; errtpi = '0;
        @(negedge clock);
        abt_valid = 1'b0;
    endtask

    // Drives one memory instruction from accept through to its WB cycle.
    task automatic run_mem(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [1:0] mask, input logic rsign, input logic [4:0] ard,
                           input int unsigned delay, input logic [31:0] rdata, input logic rerr,
                           input logic [31:0] exp_addr, input logic [31:0] exp_wdata,
                           input logic [3:0] exp_strb);
        offer(1'b1, wr, addr, wdata, mask, rsign, ard, 32'h0);
        for (int unsigned i = 0; i <= delay; i++) begin
            chk("req_valid", mem_req_valid, 1);
            chk("req_addr", mem_addr, exp_addr);
            chk("req_wdata", mem_wdata, exp_wdata);
            chk("req_wstrb", mem_wstrb, exp_strb);
            chk("req_wen", mem_wen, wr);
            mem_req_ready = (i == delay);
            @(negedge clock);
        end
        mem_req_ready = 1'b0;
        chk("resp_ready", mem_resp_ready, 1);
        chk("resp_no_req", mem_req_valid, 0);
        mem_resp_valid = 1'b1; mem_rdata = rdata; mem_resp_err = rerr;
        @(negedge clock);
        mem_resp_valid = 1'b0; mem_resp_err = 1'b0;
    endtask

    initial begin
        @(negedge clock);
        @(negedge clock);
        chk("rst_ready", abt_ready, 1);
        chk("rst_req", mem_req_valid, 0);
        chk("rst_resp_rdy", mem_resp_ready, 0);
        chk("rst_finish", abt_finish, 0);
        chk("rst_gpr_wen", gpr_wen, 0);
        chk("rst_csr_wen", csr_wen, 0);
        chk("rst_erro", erro, 0);
        chk("rst_errtpo", errtpo, 0);
        chk("rst_frd", abt_frd, 0);
        chk("rst_pc", commit_pc, 0);
        reset = 1'b0;
        @(negedge clock);

        // ALU op: retires the cycle after accept
        offer(1'b0, 1'b0, 32'h0, 32'h0, 2'b11, 1'b0, 5'd5, 32'h1234);
        chk("alu_req", mem_req_valid, 0);
        chk("alu_finish", abt_finish, 1);
        chk("alu_frd", abt_frd, 5);
        chk("alu_gpr_wen", gpr_wen, 1);
        chk("alu_waddr", gpr_waddr, 5);
        chk("alu_wdata", gpr_wdata, 32'h1234);
        chk("alu_pc", commit_pc, 32'h8000_1000);
        chk("alu_erro", erro, 0);
        chk("alu_ready_wb", abt_ready, 0);
        @(negedge clock);
        chk("alu_idle_finish", abt_finish, 0);
        chk("alu_idle_ready", abt_ready, 1);
        chk("alu_idle_frd", abt_frd, 0);

        // LB signed / unsigned at byte offset 3
        run_mem(1'b0, 32'h8000_0003, 32'h0, 2'b01, 1'b1, 5'd3, 0, 32'h80FF_0000, 1'b0,
                32'h8000_0000, 32'h0, 4'b1000);
        chk("lb_s_data", gpr_wdata, 32'hFFFF_FF80);
        chk("lb_s_wen", gpr_wen, 1);
        chk("lb_s_finish", abt_finish, 1);
        @(negedge clock);
        run_mem(1'b0, 32'h8000_0003, 32'h0, 2'b01, 1'b0, 5'd3, 0, 32'h80FF_0000, 1'b0,
                32'h8000_0000, 32'h0, 4'b1000);
        chk("lb_u_data", gpr_wdata, 32'h0000_0080);
        @(negedge clock);

        // LH signed, upper half
        run_mem(1'b0, 32'h0000_1002, 32'h0, 2'b10, 1'b1, 5'd10, 1, 32'h8001_1234, 1'b0,
                32'h0000_1000, 32'h0, 4'b1100);
        chk("lh_s_data", gpr_wdata, 32'hFFFF_8001);
        @(negedge clock);

        // SH with ready held off three cycles
        run_mem(1'b1, 32'h0010_0002, 32'h0000_ABCD, 2'b10, 1'b0, 5'd9, 3, 32'h0, 1'b0,
                32'h0010_0000, 32'hABCD_ABCD, 4'b1100);
        chk("sh_gpr_wen", gpr_wen, 0);
        chk("sh_finish", abt_finish, 1);
        chk("sh_erro", erro, 0);
        @(negedge clock);

        // Load to x0 never writes
        run_mem(1'b0, 32'h0000_2000, 32'h0, 2'b11, 1'b0, 5'd0, 0, 32'hDEAD_BEEF, 1'b0,
                32'h0000_2000, 32'h0, 4'hF);
        chk("x0_gpr_wen", gpr_wen, 0);
        chk("x0_data", gpr_wdata, 32'hDEAD_BEEF);
        @(negedge clock);

        // Bus faults: load 5, store 7
        run_mem(1'b0, 32'h0000_2000, 32'h0, 2'b11, 1'b0, 5'd7, 0, 32'h0, 1'b1,
                32'h0000_2000, 32'h0, 4'hF);
        chk("lw_fault_wen", gpr_wen, 0);
        chk("lw_fault_erro", erro, 1);
        chk("lw_fault_tp", errtpo, 5);
        chk("lw_fault_finish", abt_finish, 1);
        chk("lw_fault_frd", abt_frd, 7);
        @(negedge clock);
        chk("post_fault_erro", erro, 0);
        run_mem(1'b1, 32'h0000_2004, 32'h5555_AAAA, 2'b11, 1'b0, 5'd7, 0, 32'h0, 1'b1,
                32'h0000_2004, 32'h5555_AAAA, 4'hF);
        chk("sw_fault_tp", errtpo, 7);
        @(negedge clock);

        // Trap passthrough: CSR write survives the exception
        abt_valid = 1'b1; abt_men = 1'b0; abt_write = 1'b0; abt_gen = 1'b1; abt_ard = 5'd1;
        abt_rd = 32'h77; abt_sen = 1'b1; abt_acsr = 12'h341; abt_csr = 32'h8000_0010;
        abt_pc = 32'h8000_0200; erri = 1'b1; errtpi = 4'd11;
        @(negedge clock);
        abt_valid = 1'b0; erri = 1'b0; errtpi = '0; abt_sen = 1'b0;
        chk("trap_csr_wen", csr_wen, 1);
        chk("trap_csr_addr", csr_waddr, 12'h341);
        chk("trap_csr_data", csr_wdata, 32'h8000_0010);
        chk("trap_erro", erro, 1);
        chk("trap_tp", errtpo, 11);
        chk("trap_gpr_wen", gpr_wen, 0);
        chk("trap_pc", commit_pc, 32'h8000_0200);
        @(negedge clock);
        chk("trap_idle_csr", csr_wen, 0);

        // Response arriving with the request handshake is not sampled until RESP
        offer(1'b1, 1'b0, 32'h0000_4000, 32'h0, 2'b11, 1'b0, 5'd6, 32'h0);
        mem_req_ready = 1'b1; mem_resp_valid = 1'b1; mem_rdata = 32'h1111_1111;
        @(negedge clock);
        mem_req_ready = 1'b0; mem_rdata = 32'h2222_2222;
        chk("same_resp_rdy", mem_resp_ready, 1);
        chk("same_finish", abt_finish, 0);
        @(negedge clock);
        mem_resp_valid = 1'b0;
        chk("same_finish_wb", abt_finish, 1);
        chk("same_data", gpr_wdata, 32'h2222_2222);
        @(negedge clock);

`ifdef YSYX_25040111_MISALIGN_CHK_EN
        offer(1'b1, 1'b0, 32'h0000_5002, 32'h0, 2'b11, 1'b0, 5'd8, 32'h0);
        chk("mis_lw_req", mem_req_valid, 0);
        chk("mis_lw_finish", abt_finish, 1);
        chk("mis_lw_erro", erro, 1);
        chk("mis_lw_tp", errtpo, 4);
        chk("mis_lw_wen", gpr_wen, 0);
        @(negedge clock);
        offer(1'b1, 1'b1, 32'h0000_5001, 32'h0, 2'b10, 1'b0, 5'd8, 32'h0);
        chk("mis_sh_req", mem_req_valid, 0);
        chk("mis_sh_tp", errtpo, 6);
        @(negedge clock);
`else
        // Without the check, half at offset 3 keeps only the low strobe lane
        run_mem(1'b1, 32'h0000_5003, 32'h0000_1234, 2'b10, 1'b0, 5'd8, 0, 32'h0, 1'b0,
                32'h0000_5000, 32'h1234_1234, 4'b1000);
        chk("o3_sh_erro", erro, 0);
        @(negedge clock);
        run_mem(1'b0, 32'h0000_5003, 32'h0, 2'b10, 1'b0, 5'd8, 0, 32'hAB00_0000, 1'b0,
                32'h0000_5000, 32'h0, 4'b1000);
        chk("o3_lh_data", gpr_wdata, 32'h0000_00AB);
        chk("o3_lh_wen", gpr_wen, 1);
        @(negedge clock);
`endif

        // Reset while waiting in RESP
        offer(1'b1, 1'b0, 32'h0000_3000, 32'h0, 2'b11, 1'b0, 5'd4, 32'h0);
        mem_req_ready = 1'b1;
        @(negedge clock);
        mem_req_ready = 1'b0;
        chk("rr_resp_rdy", mem_resp_ready, 1);
        reset = 1'b1; mem_resp_valid = 1'b1; mem_rdata = 32'h55;
        @(negedge clock);
        reset = 1'b0;
        chk("rr_ready", abt_ready, 1);
        chk("rr_resp_rdy0", mem_resp_ready, 0);
        chk("rr_finish", abt_finish, 0);
        @(negedge clock);
        mem_resp_valid = 1'b0;
        chk("rr_finish2", abt_finish, 0);
        chk("rr_gpr_wen", gpr_wen, 0);
        chk("rr_req", mem_req_valid, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
